udma_ch_req_arbiter: RTL

Round-robin arbiter and request buffer sitting directly downstream of the per-channel address generators. Each cycle it selects one enabled, requesting channel and grants it. The grant is the pulse the address generator uses to advance its address and byte counter. The selected address, byte enables and channel ID are captured into a small FIFO, which drives the L2 request port. FIFO fullness is returned to all address generators as their shared not-stall input.

---
 rtl/udma_pkg.sv | 31 +++
 rtl/udma_req_fifo.sv | 47 ++++
 rtl/udma_ch_req_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/udma_pkg.sv
// Shared uDMA definitions: datasize encoding, byte-enable helper and the
// request entry buffered between the channel arbiter and the L2 port.
package udma_pkg;

  localparam int UDMA_L2_AWIDTH_NOAL = 18;
  localparam int UDMA_CH_IDW         = 2;

  localparam logic [1:0] UDMA_DS_BYTE    = 2'b00;
  localparam logic [1:0] UDMA_DS_HALF    = 2'b01;
  localparam logic [1:0] UDMA_DS_WORD    = 2'b10;
  localparam logic [1:0] UDMA_DS_INVALID = 2'b11;

  // Field widths follow the default arbiter configuration.
  typedef struct packed {
    logic [UDMA_L2_AWIDTH_NOAL-3:0] addr;
    logic [3:0]                     be;
    logic [UDMA_CH_IDW-1:0]         id;
  } udma_req_t;

  function automatic logic [3:0] udma_be_f(input logic [1:0] datasize,
                                           input logic [1:0] addr_lsb);
    logic [3:0] be;
    case (datasize)
      UDMA_DS_BYTE: be = 4'b0001 << addr_lsb;
      UDMA_DS_HALF: be = 4'b0011 << {addr_lsb[1], 1'b0};
      default:      be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/udma_req_fifo.sv
// Request buffer: DEPTH-entry FIFO, head visible combinationally on rd_dat_o.
// Push is ignored while full and pop while empty; no bypass in either direction.
module udma_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign push_ok  = push_i & ~full_o;
  assign pop_ok   = pop_i & ~empty_o;
  assign wr_ptr_d = push_ok ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop_ok  ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
  assign rd_dat_o = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= wr_dat_i;
    end
  end

endmodule

// File: rtl/udma_ch_req_arbiter.sv
// Round-robin grant across address-generator channels; the winner's request is
// buffered and issued to L2. Buffer fullness stalls every channel.
module udma_ch_req_arbiter
  import udma_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int L2_AWIDTH_NOAL = UDMA_L2_AWIDTH_NOAL,
  parameter int FIFO_DEPTH     = 2,
  parameter int CH_IDW         = $clog2(N_CH)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_CH-1:0]                ch_req_i,
  input  logic [N_CH-1:0]                ch_en_i,
  input  logic [2*N_CH-1:0]              ch_datasize_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0] ch_addr_i,
  output logic [N_CH-1:0]                ch_gnt_o,
  output logic                           not_stall_o,
  output logic                           l2_req_o,
  input  logic                           l2_gnt_i,
  output logic [L2_AWIDTH_NOAL-3:0]      l2_addr_o,
  output logic [3:0]                     l2_be_o,
  output logic [CH_IDW-1:0]              l2_id_o
);

  logic [N_CH-1:0]           elig;
  logic [CH_IDW-1:0]         rr_q, rr_d;
  logic [CH_IDW:0]           cand;
  logic [CH_IDW-1:0]         gnt_idx;
  logic                      gnt_vld;
  logic                      push;
  logic                      full, empty;
  logic [L2_AWIDTH_NOAL-1:0] sel_addr;
  logic [1:0]                sel_ds;
  udma_req_t                 push_ent, head_ent;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      elig[i] = ch_req_i[i] & ch_en_i[i] & (ch_datasize_i[2*i +: 2] != UDMA_DS_INVALID);
    end
  end

  // Scan offsets from the far end so the channel nearest rr_q is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      cand = {1'b0, rr_q} + (CH_IDW+1)'(off);
      if (cand >= (CH_IDW+1)'(N_CH)) cand = cand - (CH_IDW+1)'(N_CH);
      if (elig[cand[CH_IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[CH_IDW-1:0];
      end
    end
  end

  assign push = gnt_vld & ~full & ~rst_i;

  always_comb begin
    ch_gnt_o = '0;
    if (push) ch_gnt_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (gnt_idx == CH_IDW'(N_CH - 1)) ? '0 : gnt_idx + CH_IDW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  assign sel_addr = ch_addr_i[gnt_idx*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
  assign sel_ds   = ch_datasize_i[2*gnt_idx +: 2];

  always_comb begin
    push_ent.addr = sel_addr[L2_AWIDTH_NOAL-1:2];
    push_ent.be   = udma_be_f(sel_ds, sel_addr[1:0]);
    push_ent.id   = gnt_idx;
  end

  udma_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(udma_req_t))
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push),
    .wr_dat_i (push_ent),
    .pop_i    (l2_gnt_i),
    .rd_dat_o (head_ent),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign not_stall_o = ~full;
  assign l2_req_o    = ~empty;
  assign l2_addr_o   = head_ent.addr;
  assign l2_be_o     = head_ent.be;
  assign l2_id_o     = head_ent.id;

endmodule
